// File: rtl/decoder_pipe.sv
// decoder_pipe: registered binary-to-vector decoder with a valid/ready handshake.
// It has four decode modes (one-hot, thermometer, inverted one-hot, accumulate)
// and a sticky mask that accumulates mode-3 indices until it is cleared.
module decoder_pipe #(
    parameter int unsigned IN_W  = 5,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_oor,
    output logic [OUT_W-1:0] sticky
);

    localparam logic [1:0] ModeOneHot = 2'd0;
    localparam logic [1:0] ModeTherm  = 2'd1;
    localparam logic [1:0] ModeInv    = 2'd2;
    localparam logic [1:0] ModeAcc    = 2'd3;

    logic             acc;
    logic [31:0]      idx;
    logic             oor;
    logic [OUT_W-1:0] oh;
    logic [OUT_W-1:0] therm;
    logic [OUT_W-1:0] sticky_next;
    logic [OUT_W-1:0] dec;

    logic             valid_q;
    logic             oor_q;
    logic [OUT_W-1:0] data_q;
    logic [OUT_W-1:0] sticky_q;

    // Single-entry stage: the slot is free if empty or being drained this cycle.
    assign in_ready = !valid_q || out_ready;
    assign acc      = in_valid && in_ready;

    // Widen the index so range comparisons work for every IN_W/OUT_W pairing.
    assign idx = 32'(in_data);
    assign oor = (idx >= OUT_W);

    // Base one-hot and thermometer vectors. An out-of-range index matches no bit,
    // and it gives an all-ones thermometer because every i is below it.
    always_comb begin
        oh    = '0;
        therm = '0;
        for (int unsigned i = 0; i < OUT_W; i++) begin
            oh[i]    = (idx == i);
            therm[i] = (i <= idx);
        end
    end

    // The clear takes effect before the new index is merged.
    assign sticky_next = (acc_clr ? '0 : sticky_q) | oh;

    // Select the decoded vector for the current mode.
    always_comb begin
        dec = oh;
        case (in_mode)
            ModeOneHot: dec = oh;
            ModeTherm:  dec = therm;
            ModeInv:    dec = ~oh;
            ModeAcc:    dec = sticky_next;
            default:    dec = oh;
        endcase
    end

    // Sticky mask: updated only by an accepted mode-3 beat or by acc_clr.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= '0;
        end else if (acc && (in_mode == ModeAcc)) begin
            sticky_q <= sticky_next;
        end else if (acc_clr) begin
            sticky_q <= '0;
        end
    end

    // Output register: load on accept. On a pop with no new beat, drop valid
    // and keep the data.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            oor_q   <= 1'b0;
        end else if (acc) begin
            valid_q <= 1'b1;
            data_q  <= dec;
            oor_q   <= oor;
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_oor   = oor_q;
    assign sticky    = sticky_q;

endmodule

// File: tb/tb_decoder_pipe.sv
// Bench for decoder_pipe. Instance a uses IN_W=5, OUT_W=32 and is checked through a
// scoreboard queue. Instance b uses IN_W=6, OUT_W=40 and covers out-of-range indices.
module tb_decoder_pipe;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance a: 5 -> 32
    logic        a_in_valid, a_in_ready, a_acc_clr, a_out_valid, a_out_ready, a_out_oor;
    logic [4:0]  a_in_data;
    logic [1:0]  a_in_mode;
    logic [31:0] a_out_data, a_sticky;

    // Instance b: 6 -> 40
    logic        b_in_valid, b_in_ready, b_acc_clr, b_out_valid, b_out_ready, b_out_oor;
    logic [5:0]  b_in_data;
    logic [1:0]  b_in_mode;
    logic [39:0] b_out_data, b_sticky;

    decoder_pipe #(.IN_W(5), .OUT_W(32)) u_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_mode(a_in_mode), .acc_clr(a_acc_clr),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_oor(a_out_oor), .sticky(a_sticky)
    );

    decoder_pipe #(.IN_W(6), .OUT_W(40)) u_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_mode(b_in_mode), .acc_clr(b_acc_clr),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_oor(b_out_oor), .sticky(b_sticky)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [32:0] sb_q[$];   // {oor, data} expected from instance a, in order

    typedef struct {
        logic [1:0]  mode;
        logic [4:0]  idx;
        logic        clr;
        logic [31:0] exp_data;
        logic [31:0] exp_sticky;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present a beat to a, wait (bounded) for acceptance, then record its expected output.
    task automatic drive_a(input logic [1:0] m, input logic [4:0] d, input logic clr,
                           input logic [31:0] ed, input logic eo);
        int n;
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_mode  = m;
        a_acc_clr  = clr;
        n = 0;
        @(negedge clk);
        while (!a_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL a_accept_timeout: got in_ready=0, expected 1 within 50 cycles");
        end else begin
            sb_q.push_back({eo, ed});
        end
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        a_acc_clr  = 1'b0;
    endtask

    // Present a beat to b (always ready) and check the registered result directly.
    task automatic drive_b(input logic [1:0] m, input logic [5:0] d, input logic [39:0] ed,
                           input logic eo, input logic [39:0] es);
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_in_mode  = m;
        check("b_in_ready", 64'(b_in_ready), 64'(1));
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        check("b_out_valid", 64'(b_out_valid), 64'(1));
        check("b_out_data", 64'(b_out_data), 64'(ed));
        check("b_out_oor", 64'(b_out_oor), 64'(eo));
        check("b_sticky", 64'(b_sticky), 64'(es));
    endtask

    // Monitor: a pop happens at the next rising edge whenever valid && ready here.
    always @(negedge clk) begin
        if (!reset && a_out_valid && a_out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL a_unexpected_beat: got %h, expected no beat", a_out_data);
            end else begin
                logic [32:0] e;
                e = sb_q.pop_front();
                check("a_beat", 64'({a_out_oor, a_out_data}), 64'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [39:0] ones40;
        time t0;
        ones40 = '1;

        vecs[0] = '{2'd0, 5'd7,  1'b0, 32'h0000_0080, 32'h0};
        vecs[1] = '{2'd1, 5'd4,  1'b0, 32'h0000_001F, 32'h0};
        vecs[2] = '{2'd2, 5'd0,  1'b0, 32'hFFFF_FFFE, 32'h0};
        vecs[3] = '{2'd3, 5'd3,  1'b0, 32'h0000_0008, 32'h8};
        vecs[4] = '{2'd3, 5'd3,  1'b0, 32'h0000_0008, 32'h8};
        vecs[5] = '{2'd3, 5'd10, 1'b0, 32'h0000_0408, 32'h408};
        vecs[6] = '{2'd3, 5'd1,  1'b1, 32'h0000_0002, 32'h2};
        vecs[7] = '{2'd0, 5'd31, 1'b0, 32'h8000_0000, 32'h2};
        vecs[8] = '{2'd1, 5'd31, 1'b0, 32'hFFFF_FFFF, 32'h2};
        vecs[9] = '{2'd2, 5'd31, 1'b0, 32'h7FFF_FFFF, 32'h2};

        // A beat presented during reset must not be accepted.
        reset = 1'b1;
        a_in_valid = 1'b1; a_in_data = 5'd7; a_in_mode = 2'd0; a_acc_clr = 1'b0;
        a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_mode = 2'd0; b_acc_clr = 1'b0;
        b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        reset = 1'b0;
        check("rst_out_valid", 64'(a_out_valid), 64'(0));
        check("rst_out_data", 64'(a_out_data), 64'(0));
        check("rst_out_oor", 64'(a_out_oor), 64'(0));
        check("rst_sticky", 64'(a_sticky), 64'(0));
        check("rst_in_ready", 64'(a_in_ready), 64'(1));

        // Table of decode vectors
        for (int i = 0; i < 10; i++) begin
            drive_a(vecs[i].mode, vecs[i].idx, vecs[i].clr, vecs[i].exp_data, 1'b0);
            check("vec_out_valid", 64'(a_out_valid), 64'(1));
            check("vec_sticky", 64'(a_sticky), 64'(vecs[i].exp_sticky));
        end

        // acc_clr with no beat clears the mask
        a_acc_clr = 1'b1;
        @(posedge clk);
        #1;
        a_acc_clr = 1'b0;
        check("clr_alone_sticky", 64'(a_sticky), 64'(0));

        // Streaming 0..31 back-to-back: one beat per cycle
        t0 = $time;
        for (int i = 0; i < 32; i++) begin
            drive_a(2'd0, 5'(i), 1'b0, 32'h1 << i, 1'b0);
        end
        check("stream_cycles", 64'(($time - t0) / 10), 64'(32));
        repeat (2) @(posedge clk);
        #1;
        check("stream_drained", 64'(a_out_valid), 64'(0));

        // Back-pressure: hold one beat for 3 cycles while more beats wait
        a_out_ready = 1'b0;
        drive_a(2'd0, 5'd1, 1'b0, 32'h2, 1'b0);
        fork
            begin
                drive_a(2'd0, 5'd2, 1'b0, 32'h4, 1'b0);
                drive_a(2'd0, 5'd3, 1'b0, 32'h8, 1'b0);
                drive_a(2'd1, 5'd2, 1'b0, 32'h7, 1'b0);
            end
            begin
                repeat (3) begin
                    check("bp_in_ready", 64'(a_in_ready), 64'(0));
                    check("bp_hold_data", 64'(a_out_data), 64'(32'h2));
                    @(posedge clk);
                    #1;
                end
                a_out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        check("bp_queue_empty", 64'(sb_q.size()), 64'(0));

        // Out-of-range and boundary indices on the 6 -> 40 instance
        drive_b(2'd3, 6'd5,  40'h20, 1'b0, 40'h20);
        drive_b(2'd0, 6'd63, 40'h0, 1'b1, 40'h20);
        drive_b(2'd1, 6'd63, ones40, 1'b1, 40'h20);
        drive_b(2'd2, 6'd63, ones40, 1'b1, 40'h20);
        drive_b(2'd3, 6'd63, 40'h20, 1'b1, 40'h20);
        drive_b(2'd1, 6'd39, ones40, 1'b0, 40'h20);
        drive_b(2'd0, 6'd39, 40'h80_0000_0000, 1'b0, 40'h20);
        drive_b(2'd0, 6'd40, 40'h0, 1'b1, 40'h20);

        // Reset mid-stream with a held beat and sticky = 0x5
        drive_a(2'd3, 5'd0, 1'b1, 32'h1, 1'b0);
        drive_a(2'd3, 5'd2, 1'b0, 32'h5, 1'b0);
        a_out_ready = 1'b0;
        check("pre_rst_sticky", 64'(a_sticky), 64'(32'h5));
        check("pre_rst_valid", 64'(a_out_valid), 64'(1));
        reset = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_rst_out_valid", 64'(a_out_valid), 64'(0));
        check("mid_rst_out_data", 64'(a_out_data), 64'(0));
        check("mid_rst_sticky", 64'(a_sticky), 64'(0));
        check("mid_rst_in_ready", 64'(a_in_ready), 64'(1));

        // Recovery after reset
        a_out_ready = 1'b1;
        drive_a(2'd3, 5'd4, 1'b0, 32'h10, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", 64'(sb_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decoder_pipe.md
# decoder_pipe

Parametrised, registered binary-to-one-hot decoder with a valid/ready handshake, four output modes and a sticky accumulate mask. It replaces fixed-size combinational decoders wherever the decoded vector feeds a pipeline stage. Typical uses are register-file write-enable generation, exception and interrupt vector marking, and TLB/cache way-select. It sits between an index producer and a registered consumer, and absorbs consumer back-pressure.

## Interface
- IN_W, default 5: index width in bits; legal range 1..8.
- OUT_W, default 32: decoded vector width; legal range 1..2**IN_W.

- clk  in  1  clock; every flop is rising-edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  the input beat is valid.
- in_ready  out  1  the block can accept a beat this cycle.
- in_data  in  IN_W  binary index.
- in_mode  in  2  decode mode, sampled with the beat: 0 one-hot, 1 thermometer, 2 inverted one-hot, 3 accumulate.
- acc_clr  in  1  clears the sticky mask; acts independently of the handshake.
- out_valid  out  1  the output register holds a beat.
- out_ready  in  1  the consumer accepts the output beat.
- out_data  out  OUT_W  decoded vector.
- out_oor  out  1  the beat's index was at or above OUT_W.
- sticky  out  OUT_W  current accumulate mask.

## Operation
- Accept condition: `acc = in_valid && in_ready`.
- Ready: `in_ready = !out_valid || out_ready`. The block is a single-entry pipeline register, so it sustains one beat per cycle.
- Base vector: `oh[i] = (in_data == i)` for i in 0..OUT_W-1.
- Out-of-range index (in_data >= OUT_W): oh is all zeros and out_oor = 1.
- Mode 0 (one-hot): out_data = oh.
- Mode 1 (thermometer): `out_data[i] = (i <= in_data)`. An out-of-range index gives all ones, with out_oor = 1.
- Mode 2 (inverted one-hot): out_data = ~oh. An out-of-range index gives all ones.
- Mode 3 (accumulate): `sticky_next = (acc_clr ? 0 : sticky) | oh`, and out_data = sticky_next.
- Sticky update rules:
  - Sticky changes only on an accepted mode-3 beat, or on acc_clr.
  - Beats in modes 0–2 never modify sticky.
  - acc_clr with no mode-3 accept: sticky becomes 0 next cycle.
  - acc_clr in the same cycle as a mode-3 accept: the clear applies first, then the new bit is set, so sticky = oh.
- Out-of-range index in mode 3: sticky is unchanged (apart from a coincident acc_clr). out_data = sticky_next, and out_oor = 1.
- Output register update:
  - On acc: out_data, out_oor and out_valid = 1 load.
  - When out_valid && out_ready && !acc: out_valid goes to 0. out_data and out_oor keep their last value.
  - out_data is stable while out_valid && !out_ready.

## Timing
- Latency: one cycle. A beat accepted at edge N appears on out_data/out_valid after edge N.
- Throughput: one beat per cycle with out_ready held high. A pop and a new accept in the same cycle are legal.
- in_ready is combinational from out_valid and out_ready. There is no combinational path from in_data to any output.
- Back-pressure: while out_valid=1 and out_ready=0, in_ready=0. Input beats are held by the producer, never dropped.
- Reset values: out_valid=0, out_data=0, out_oor=0, sticky=0. in_ready=1 in the cycle after reset.
- Reset priority:
  - reset overrides acc, acc_clr and any pop.
  - A beat presented during reset is not accepted.
  - Reset asserted mid-stream discards the held output beat and the sticky mask.
- Parameter edge cases:
  - OUT_W = 2**IN_W: out_oor never asserts.
  - IN_W=1, OUT_W=1: index 1 is out of range.

## Test plan
- After reset, check the idle state:
  - Stimulus: IN_W=5, OUT_W=32; in_valid=1, in_data=7, mode 0, out_ready=1.
  - Response: one cycle later out_data=0x0000_0080, out_valid=1, out_oor=0.
  - Streaming indices 0..31 back-to-back yields 32 consecutive one-hot outputs with no bubbles.
- Thermometer and inverted modes, same parameters:
  - Mode 1, in_data=4 gives 0x0000_001F.
  - Mode 2, in_data=0 gives 0xFFFF_FFFE.
- Accumulate:
  - Mode 3 beats 3, 3, 10 give out_data 0x8, 0x8, 0x408, and sticky=0x408.
  - acc_clr together with a mode-3 beat for index 1 gives sticky=0x2.
  - acc_clr alone gives sticky=0.
- Out of range, IN_W=6, OUT_W=40:
  - in_data=63 in mode 0 gives out_data=0, out_oor=1.
  - Mode 1 gives all ones (40 bits).
  - Mode 3 leaves sticky unchanged.
- Back-pressure:
  - Hold out_ready=0 for 3 cycles with in_valid=1, then release.
  - in_ready=0 while the output is held and out_data stays stable.
  - Following beats emerge in order, with none lost or duplicated.
- Reset mid-stream:
  - Assert reset while out_valid=1, out_ready=0 and sticky=0x5.
  - Next cycle: out_valid=0, out_data=0, sticky=0, in_ready=1.
